parking_exit_controller: RTL and testbench

Handles departures for the 8-slot parking lot, mirroring the entry-side capacity update. An exit request names a slot; the block checks that the slot is occupied, opens the exit gate for a fixed number of cycles, then clears that slot's bit in the occupancy vector and counts the departure. It sits between the exit-kiosk request logic and the occupancy register that the entry path also updates.

---
 rtl/parking_exit_controller_pkg.sv | 22 ++
 rtl/parking_exit_controller_gate_timer.sv | 28 ++
 rtl/parking_exit_controller.sv | 104 ++++++++++
 tb/tb_parking_exit_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/parking_exit_controller_pkg.sv
// Shared parking-lot definitions: slot geometry, exit FSM state encoding and
// a slot-to-mask helper used by the exit path (and reusable by the entry path).
package parking_exit_controller_pkg;

  localparam int SLOT_COUNT = 8;
  localparam int SLOT_IDX_W = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_OPEN    = 2'd2,
    S_RELEASE = 2'd3
  } exit_state_t;

  function automatic logic [SLOT_COUNT-1:0] slot_mask(input logic [SLOT_IDX_W-1:0] idx);
    logic [SLOT_COUNT-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/parking_exit_controller_gate_timer.sv
// Loadable down-counter for gate hold time; done flags the final open cycle
// so the owning FSM can leave on exactly the programmed count.
module gate_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/parking_exit_controller.sv
// Exit-side controller: validates the requested slot, holds the exit gate open
// for GATE_CYCLES, then publishes the cleared occupancy and counts departures.
module parking_exit_controller
  import parking_exit_controller_pkg::*;
#(
  parameter int GATE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exit_req,
  input  logic [SLOT_IDX_W-1:0] exit_slot,
  input  logic [SLOT_COUNT-1:0] parking_capacity,
  output logic                  busy,
  output logic                  gate_open,
  output logic                  exit_error,
  output logic                  release_valid,
  output logic [SLOT_COUNT-1:0] release_mask,
  output logic [SLOT_COUNT-1:0] new_capacity,
  output logic [7:0]            exit_count
);

  localparam logic [7:0] GATE_LOAD = 8'(GATE_CYCLES);

  exit_state_t           state;
  exit_state_t           next_state;
  logic [SLOT_IDX_W-1:0] slot_q;
  logic                  slot_hit;
  logic                  timer_load;
  logic                  timer_dec;
  logic                  timer_done;
  logic [SLOT_COUNT-1:0] slot_bit;

  assign slot_hit = parking_capacity[slot_q];
  assign slot_bit = slot_mask(slot_q);

  gate_timer #(
    .CNT_W (8)
  ) u_gate_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (GATE_LOAD),
    .dec      (timer_dec),
    .done     (timer_done)
  );

  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (exit_req) next_state = S_CHECK;
      end
      S_CHECK: begin
        if (slot_hit) begin
          next_state = S_OPEN;
          timer_load = 1'b1;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_OPEN: begin
        timer_dec = 1'b1;
        if (timer_done) next_state = S_RELEASE;
      end
      S_RELEASE: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from next_state so each one lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      slot_q        <= '0;
      busy          <= 1'b0;
      gate_open     <= 1'b0;
      exit_error    <= 1'b0;
      release_valid <= 1'b0;
      release_mask  <= '0;
      new_capacity  <= '0;
      exit_count    <= '0;
    end else begin
      state         <= next_state;
      if ((state == S_IDLE) && exit_req) slot_q <= exit_slot;
      busy          <= (next_state != S_IDLE);
      gate_open     <= (next_state == S_OPEN);
      exit_error    <= (state == S_CHECK) && !slot_hit;
      release_valid <= (next_state == S_RELEASE);
      if (next_state == S_RELEASE) begin
        // Occupancy is sampled live here so entry-side changes made while open survive.
        release_mask <= slot_bit;
        new_capacity <= parking_capacity & ~slot_bit;
        if (exit_count != 8'hFF) exit_count <= exit_count + 8'd1;
      end else begin
        release_mask <= '0;
      end
    end
  end

endmodule

// File: tb/tb_parking_exit_controller.sv
// Directed bench for parking_exit_controller with hand-computed expectations.
module tb_parking_exit_controller;

  logic       clk;
  logic       reset;
  logic       exit_req;
  logic [2:0] exit_slot;
  logic [7:0] parking_capacity;
  logic       busy;
  logic       gate_open;
  logic       exit_error;
  logic       release_valid;
  logic [7:0] release_mask;
  logic [7:0] new_capacity;
  logic [7:0] exit_count;

  int n_checks;
  int n_errors;

  parking_exit_controller #(
    .GATE_CYCLES (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .exit_req         (exit_req),
    .exit_slot        (exit_slot),
    .parking_capacity (parking_capacity),
    .busy             (busy),
    .gate_open        (gate_open),
    .exit_error       (exit_error),
    .release_valid    (release_valid),
    .release_mask     (release_mask),
    .new_capacity     (new_capacity),
    .exit_count       (exit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle request; returns just after the accepting edge.
  task automatic do_req(input logic [2:0] slot);
    exit_slot = slot;
    exit_req  = 1'b1;
    step();
    exit_req  = 1'b0;
  endtask

  int pulses;
  int waited;

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    reset            = 1'b1;
    exit_req         = 1'b0;
    exit_slot        = 3'd0;
    parking_capacity = 8'h00;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_gate", gate_open, 0);
    chk("rst_err", exit_error, 0);
    chk("rst_rv", release_valid, 0);
    chk("rst_mask", release_mask, 0);
    chk("rst_cap", new_capacity, 0);
    chk("rst_cnt", exit_count, 0);
    reset = 1'b0;
    step();

    // Valid release of slot 2
    parking_capacity = 8'b1010_0110;
    do_req(3'd2);
    chk("t1_busy_check", busy, 1);
    chk("t1_gate_check", gate_open, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t1_gate_open", gate_open, 1);
      chk("t1_rv_open", release_valid, 0);
    end
    step();
    chk("t1_gate_rel", gate_open, 0);
    chk("t1_rv", release_valid, 1);
    chk("t1_mask", release_mask, 8'h04);
    chk("t1_newcap", new_capacity, 8'b1010_0010);
    chk("t1_cnt", exit_count, 1);
    chk("t1_busy_rel", busy, 1);
    step();
    chk("t1_rv_end", release_valid, 0);
    chk("t1_mask_end", release_mask, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_newcap_hold", new_capacity, 8'b1010_0010);

    // Exit from an empty slot
    parking_capacity = 8'h00;
    do_req(3'd5);
    chk("t2_err_early", exit_error, 0);
    step();
    chk("t2_err", exit_error, 1);
    chk("t2_gate", gate_open, 0);
    chk("t2_busy", busy, 0);
    step();
    chk("t2_err_end", exit_error, 0);
    chk("t2_gate2", gate_open, 0);
    chk("t2_cnt", exit_count, 1);

    // Request while busy is ignored; slot 7 occupied so acceptance would be visible
    parking_capacity = 8'hFF;
    do_req(3'd0);
    step();
    step();
    do_req(3'd7);
    step();
    step();
    chk("t3_rv", release_valid, 1);
    chk("t3_mask", release_mask, 8'h01);
    chk("t3_newcap", new_capacity, 8'hFE);
    chk("t3_busy_rel", busy, 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (release_valid || busy) pulses++;
    end
    chk("t3_no_second", pulses, 0);
    chk("t3_cnt", exit_count, 2);

    // Concurrent entry on slot 7 while slot 0 gate is open
    parking_capacity = 8'h01;
    do_req(3'd0);
    step();
    step();
    parking_capacity = 8'h81;
    step();
    step();
    step();
    chk("t4_rv", release_valid, 1);
    chk("t4_newcap", new_capacity, 8'h80);
    chk("t4_cnt", exit_count, 3);
    step();

    // Counter saturation: reset count, then 256 back-to-back exits
    reset = 1'b1;
    step();
    reset = 1'b0;
    parking_capacity = 8'hFF;
    for (int n = 1; n <= 256; n++) begin
      do_req(3'(n % 8));
      waited = 0;
      while (busy && waited < 20) begin
        step();
        waited++;
      end
      if (waited >= 20) chk("sat_timeout", busy, 0);
      if (n == 254) chk("sat_254", exit_count, 254);
      if (n == 255) chk("sat_255", exit_count, 255);
    end
    chk("sat_256", exit_count, 255);

    // Reset during cycle 2 of OPEN
    parking_capacity = 8'h02;
    do_req(3'd1);
    step();
    step();
    chk("t6_gate_pre", gate_open, 1);
    reset = 1'b1;
    step();
    chk("t6_gate", gate_open, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cnt", exit_count, 0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (release_valid) pulses++;
      step();
    end
    chk("t6_no_release", pulses, 0);
    chk("t6_cnt_end", exit_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
